// File: rtl/enc_pkg.sv
// enc_pkg: shared sizes, FSM states and fixed-point arithmetic for encoder layers
package enc_pkg;
  localparam int BITSIZE = 16;
  localparam int FRAC    = 8;
  localparam int N_IN    = 10;
  localparam int N_OUT   = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;
  // full-width signed product, floor shift by FRAC, low word kept (wraps)
  function automatic logic [BITSIZE-1:0] fx_mul(input logic [BITSIZE-1:0] a, input logic [BITSIZE-1:0] c);
    logic signed [2*BITSIZE-1:0] p;
    p = ($signed(a) * $signed(c)) >>> FRAC;
    return p[BITSIZE-1:0];
  endfunction
  // two's complement wrapping add
  function automatic logic [BITSIZE-1:0] fx_add(input logic [BITSIZE-1:0] a, input logic [BITSIZE-1:0] c);
    return a + c;
  endfunction
endpackage

// File: rtl/enc_layer_seq_mac_lane.sv
// mac_lane: one output accumulator, restarting from the bias on the first element
module mac_lane
  import enc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               first,
  input  logic [BITSIZE-1:0] a,
  input  logic [BITSIZE-1:0] c,
  input  logic [BITSIZE-1:0] bias,
  output logic [BITSIZE-1:0] acc,
  output logic [BITSIZE-1:0] prod
);
  assign prod = fx_mul(a, c);
  // accumulate one product per enabled cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc <= '0;
    else if (en) acc <= fx_add(first ? bias : acc, prod);
  end
endmodule

// File: rtl/enc_layer_seq.sv
// enc_layer_seq: job sequencer for y = W*x + b over N_OUT parallel MAC lanes
module enc_layer_seq
  import enc_pkg::*;
#(
  parameter int BITSIZE = enc_pkg::BITSIZE,
  parameter int FRAC    = enc_pkg::FRAC,
  parameter int N_IN    = enc_pkg::N_IN,
  parameter int N_OUT   = enc_pkg::N_OUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BITSIZE*N_IN-1:0]       x,
  input  logic [BITSIZE*N_OUT*N_IN-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]      b,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITSIZE*N_OUT-1:0]      y
);
  localparam int IW = $clog2(N_IN);
  state_t                        r_state;
  logic [IW-1:0]                 r_idx;
  logic [BITSIZE*N_IN-1:0]       r_x;
  logic [BITSIZE*N_OUT*N_IN-1:0] r_w;
  logic [BITSIZE*N_OUT-1:0]      r_b;
  logic [BITSIZE*N_OUT-1:0]      r_y;
  logic                          r_valid;
  logic                          r_busy;
  logic                          w_en;
  logic                          w_first;
  logic                          w_last;
  logic [BITSIZE-1:0]            w_a;
  logic [BITSIZE*N_OUT-1:0]      w_acc;
  logic [BITSIZE*N_OUT-1:0]      w_prod;
  logic [BITSIZE*N_OUT-1:0]      w_fin;
  assign w_en      = r_state == ACC;
  assign w_first   = r_idx == '0;
  assign w_last    = r_idx == IW'(N_IN - 1);
  assign w_a       = r_x[BITSIZE*r_idx +: BITSIZE];
  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign y         = r_y;
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    mac_lane u_lane (
      .clk  (clk),
      .reset(reset),
      .en   (w_en),
      .first(w_first),
      .a    (w_a),
      .c    (r_w[BITSIZE*(N_OUT*r_idx + k) +: BITSIZE]),
      .bias (r_b[BITSIZE*k +: BITSIZE]),
      .acc  (w_acc[BITSIZE*k +: BITSIZE]),
      .prod (w_prod[BITSIZE*k +: BITSIZE])
    );
    // the last step never restarts from bias (N_IN >= 2), so it is acc + product
    assign w_fin[BITSIZE*k +: BITSIZE] = fx_add(w_acc[BITSIZE*k +: BITSIZE], w_prod[BITSIZE*k +: BITSIZE]);
  end
  // job FSM: capture operands, step idx, hold the result until handed off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_x     <= '0;
      r_w     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= ACC;
          r_idx   <= '0;
          r_x     <= x;
          r_w     <= w;
          r_b     <= b;
          r_busy  <= 1'b1;
        end
        ACC: begin
          r_idx <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_valid <= 1'b1;
            r_y     <= w_fin;
          end
        end
        DONE: if (out_ready) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_enc_layer_seq.sv
// tb_enc_layer_seq: directed jobs with a queue scoreboard checked by an output monitor
module tb_enc_layer_seq;
  localparam int BS = 16;
  localparam int NI = 10;
  localparam int NO = 6;
  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                out_ready = 1'b1;
  logic [BS*NI-1:0]    x;
  logic [BS*NO*NI-1:0] w;
  logic [BS*NO-1:0]    b;
  logic                busy;
  logic                out_valid;
  logic [BS*NO-1:0]    y;
  logic [BS-1:0]       xv [NI];
  logic [BS-1:0]       wv [NI][NO];
  logic [BS-1:0]       bv [NO];
  logic [BS*NO-1:0]    sb_q[$];
  int                  n_chk = 0;
  int                  n_fail = 0;

  enc_layer_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .w        (w),
    .b        (b),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
  );

  always #5 clk = ~clk;

  always_comb begin
    x = '0;
    w = '0;
    b = '0;
    for (int i = 0; i < NI; i++) begin
      x[BS*i +: BS] = xv[i];
      for (int k = 0; k < NO; k++) w[BS*NO*i + BS*k +: BS] = wv[i][k];
    end
    for (int k = 0; k < NO; k++) b[BS*k +: BS] = bv[k];
  end

  task automatic check(input string name, input logic [BS*NO-1:0] act, input logic [BS*NO-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ops();
    for (int i = 0; i < NI; i++) begin
      xv[i] = '0;
      for (int k = 0; k < NO; k++) wv[i][k] = '0;
    end
    for (int k = 0; k < NO; k++) bv[k] = '0;
  endtask

  function automatic logic [BS*NO-1:0] pack(input logic [BS-1:0] e0, e1, e2, e3, e4, e5);
    return {e5, e4, e3, e2, e1, e0};
  endfunction

  // monitor: every accepted result is compared with the oldest expectation
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got %h expected none", y);
      end else check("y", y, sb_q.pop_front());
    end
  end

  // issue start; returns after the accepting edge
  task automatic issue(input logic [BS*NO-1:0] exp);
    sb_q.push_back(exp);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // wait for out_valid, checking busy and the cycle latency
  task automatic wait_valid();
    int lat;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      lat = c;
      if (out_valid) break;
      check("busy_during_acc", {95'd0, busy}, {95'd0, 1'b1});
    end
    check("latency", (BS*NO)'(lat), (BS*NO)'(NI));
  endtask

  task automatic run(input logic [BS*NO-1:0] exp);
    issue(exp);
    wait_valid();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_ops();
    #12;
    check("reset_y", y, '0);
    check("reset_flags", {93'd0, busy, out_valid}, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      xv[i] = 16'h0100;
      for (int k = 0; k < NO; k++) wv[i][k] = 16'h0100;
    end
    run({NO{16'h0A00}});
    clear_ops();
    for (int k = 0; k < NO; k++) begin
      bv[k] = 16'(k * 256);
      wv[3][k] = 16'h0100;
    end
    run(pack(16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500));
    clear_ops();
    xv[0] = 16'hFF00;
    for (int k = 0; k < NO; k++) wv[0][k] = 16'h0200;
    run({NO{16'hFE00}});
    clear_ops();
    xv[0] = 16'h0080;
    wv[0][0] = 16'h0001;
    run('0);
    clear_ops();
    xv[0] = 16'hFFFF;
    wv[0][0] = 16'h0080;
    run(pack(16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    clear_ops();
    xv[0] = 16'h7F00;
    wv[0][0] = 16'h0200;
    wv[1][1] = 16'h0100;
    xv[1] = 16'h0300;
    run(pack(16'hFE00, 16'h0300, 16'h0, 16'h0, 16'h0, 16'h0));
    // backpressure: result held, starts ignored
    clear_ops();
    for (int i = 0; i < NI; i++) begin
      xv[i] = 16'h0100;
      for (int k = 0; k < NO; k++) wv[i][k] = 16'h0100;
    end
    bv[2] = 16'h0001;
    out_ready = 1'b0;
    issue(pack(16'h0A00, 16'h0A00, 16'h0A01, 16'h0A00, 16'h0A00, 16'h0A00));
    wait_valid();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 start = c[0];
      @(negedge clk);
      check("hold_y", y, pack(16'h0A00, 16'h0A00, 16'h0A01, 16'h0A00, 16'h0A00, 16'h0A00));
      check("hold_flags", {94'd0, busy, out_valid}, {94'd0, 2'b11});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("handshake_no_accept", {94'd0, busy, out_valid}, '0);
    sb_q.push_back(pack(16'h0A00, 16'h0A00, 16'h0A01, 16'h0A00, 16'h0A00, 16'h0A00));
    @(posedge clk);
    #1 start = 1'b0;
    check("next_edge_accept", {95'd0, busy}, {95'd0, 1'b1});
    clear_ops();
    wait_valid();
    @(posedge clk);
    #1;
    // reset in the middle of a job
    xv[5] = 16'h0100;
    wv[5][4] = 16'h0100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_y", y, '0);
    check("abort_flags", {94'd0, busy, out_valid}, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    run(pack(16'h0, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0));
    repeat (2) @(posedge clk);
    check("scoreboard_empty", (BS*NO)'(sb_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/enc_layer_seq.md
Name: enc_layer_seq

Overview:
- Sequencer plus accumulator bank for one dense encoder layer, y = W·x + b.
- N_IN inputs, N_OUT outputs, signed fixed point.
- Accepts a layer job with a start pulse and captures operands.
- Steps one input element per cycle across N_OUT parallel MAC lanes.
- Presents the result with a valid/ready handshake; sits between the layer-operand source and the next encoder stage.

Parameters:
- BITSIZE, 16, word width of every x, w, b, y element (signed two's complement).
- FRAC, 8, fractional bits (Q(BITSIZE-FRAC).FRAC).
- N_IN, 10, input vector length (≥2).
- N_OUT, 6, output vector length (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job request, sampled only in IDLE.
- x  in  BITSIZE*N_IN  input vector; element i at [BITSIZE*i +: BITSIZE].
- w  in  BITSIZE*N_OUT*N_IN  weights; w(i,k) at [BITSIZE*N_OUT*i + BITSIZE*k +: BITSIZE].
- b  in  BITSIZE*N_OUT  bias; element k at [BITSIZE*k +: BITSIZE].
- busy  out  1  high whenever state ≠ IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- y  out  BITSIZE*N_OUT  result; element k at [BITSIZE*k +: BITSIZE]. Natural order, no reversal.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, idx=0, all accumulators=0, y=0, out_valid=0, busy=0. Operand registers cleared.
- FSM states: IDLE, ACC, DONE.
- IDLE→ACC on an edge with start=1. Same edge: capture x, w, b into internal registers; idx←0.
- Inputs may change freely after capture.
- start is ignored in ACC and DONE. It is not queued.
- ACC, each edge:
  - acc_k ← (idx==0 ? b_k : acc_k) + mul(x_idx, w(idx,k)) for all k in parallel.
  - idx←idx+1.
  - On the edge with idx==N_IN-1: go to DONE; out_valid←1; y←final acc values.
- Latency: out_valid rises N_IN edges after the accepting edge (10 cycles by default).
- DONE: y and out_valid are held stable while out_ready=0.
- On an edge with out_valid&out_ready: go to IDLE and set out_valid←0. y keeps its last value until the next job completes.
- start=1 on the same edge as the DONE handshake is not accepted. The earliest new start is the following edge.
- mul(a,c): full 2*BITSIZE signed product, arithmetic right shift by FRAC (floor), low BITSIZE bits kept. Wraps, no saturation.
- Add: BITSIZE-bit two's complement wrap, no saturation.
- idx counter width is clog2(N_IN). idx is never ≥N_IN while in ACC.
- Reset asserted mid-ACC or mid-DONE aborts the job immediately; no partial result is exposed (out_valid=0, y=0).
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (enc_pkg):
  - BITSIZE/FRAC/N_IN/N_OUT defaults.
  - State encoding localparams: IDLE=2'd0, ACC=2'd1, DONE=2'd2.
  - fixed-point mul/add functions, so all encoder layers agree on rounding and wrap.
- Sub-module mac_lane (one lane):
  - Inputs: clk, reset, en, first, a, c, bias.
  - Output: registered acc.
  - Instantiated N_OUT times by a generate loop.
- The top level holds only the FSM, idx counter, operand capture and handshake.

Test Plan:
- All x=0x0100, all w=0x0100, b=0, start pulse → out_valid exactly 10 cycles after accept; every y_k=0x0A00; busy high throughout.
- x=0, b_k=k*0x0100 → y = {0x0000,0x0100,0x0200,0x0300,0x0400,0x0500} for k=0..5, verifying natural element order.
- x_0=0xFF00, w(0,k)=0x0200, rest 0, b=0 → all y_k=0xFE00.
- Floor check:
  - x_0=0x0080, w(0,0)=0x0001 → y_0=0x0000.
  - x_0=0xFFFF, w(0,0)=0x0080 → y_0=0xFFFF.
  - Wrap: x_0=0x7F00, w(0,0)=0x0200 → y_0=0xFE00.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid; y stays stable; start pulses are ignored and busy stays high.
  - Release out_ready: out_valid falls next edge; a start on that same edge is not accepted; a start one edge later is accepted.
- Drop reset low at ACC idx=4 → out_valid=0, y=0, busy=0 asynchronously. After release, a fresh job completes with correct results.
